// File: rtl/ppi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ppi_pkg
// Purpose  : Shared types and constants for the 8255A strobed input port:
//            handshake state enum, StatusBits bit positions, default width.
// Revision : 1.0 - initial release
// ============================================================================
package ppi_pkg;

    // Default data width of the port and its input buffer
    localparam int c_DEFAULT_WIDTH = 8;

    // Bit positions inside the 4-bit StatusBits field
    localparam int c_STAT_OVR  = 3;
    localparam int c_STAT_INTR = 2;
    localparam int c_STAT_IBF  = 1;
    localparam int c_STAT_INTE = 0;

    // Mode-1 input handshake states
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        STROBE  = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } hs_state_t;

endpackage : ppi_pkg
`default_nettype wire

// File: rtl/strobe_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : strobe_edge_detect
// Purpose  : Samples an active-low strobe and produces single-cycle fall and
//            rise pulses. Build option STROBE_SYNC_EN inserts a two-flop
//            synchronizer ahead of the sample flop for asynchronous strobes.
// Revision : 1.0 - initial release
// ============================================================================
module strobe_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic i_strobe_n,
    output logic o_fall,
    output logic o_rise
);

    logic w_pin;
    logic r_sample;
    logic r_hist;

`ifdef STROBE_SYNC_EN
    logic [1:0] r_sync;

    // Two-flop synchronizer; idles high like the strobe itself
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], i_strobe_n};
    end

    assign w_pin = r_sync[1];
`else
    assign w_pin = i_strobe_n;
`endif

    // Sample flop followed by the history flop used for edge comparison
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample <= 1'b1;
            r_hist   <= 1'b1;
        end else begin
            r_sample <= w_pin;
            r_hist   <= r_sample;
        end
    end

    assign o_fall = r_hist & ~r_sample;
    assign o_rise = ~r_hist & r_sample;

endmodule : strobe_edge_detect
`default_nettype wire

// File: rtl/strobed_input_port.sv
`default_nettype none
// ============================================================================
// Module   : strobed_input_port
// Purpose  : 8255A mode-1 strobed input channel (port A or B). Latches
//            PortIn on STB_n falling, drives the IBF/INTR handshake and clears
//            it on CPU buffer reads. Mode 0 makes the buffer transparent.
//            Build option STROBE_SYNC_EN: synchronize STB_n/RdBuf_n.
// Revision : 1.0 - initial release
// ============================================================================
module strobed_input_port
    import ppi_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] PortIn,
    input  logic             STB_n,
    input  logic             RdBuf_n,
    input  logic             Inte,
    input  logic             ModeStrobed,
    output logic [WIDTH-1:0] InBuf,
    output logic             IBF,
    output logic             INTR,
    output logic [3:0]       StatusBits
);

    hs_state_t r_state;
    hs_state_t w_next;
    logic      r_ovr;
    logic      w_stb_fall, w_stb_rise;
    logic      w_rd_fall, w_rd_rise;
    logic      w_latch, w_set_ibf, w_clr_ibf, w_set_ovr;

    strobe_edge_detect u_stb_edge (
        .clk        (clk),
        .reset      (reset),
        .i_strobe_n (STB_n),
        .o_fall     (w_stb_fall),
        .o_rise     (w_stb_rise)
    );

    strobe_edge_detect u_rd_edge (
        .clk        (clk),
        .reset      (reset),
        .i_strobe_n (RdBuf_n),
        .o_fall     (w_rd_fall),
        .o_rise     (w_rd_rise)
    );

    // Next-state and datapath decisions for the mode-1 handshake
    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_set_ibf = 1'b0;
        w_clr_ibf = 1'b0;
        w_set_ovr = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_stb_fall) begin
                    w_next    = STROBE;
                    w_latch   = 1'b1;
                    w_set_ibf = 1'b1;
                end
            end
            STROBE: begin
                if (w_stb_rise) w_next = FULL;
            end
            FULL: begin
                // A new strobe overwrites unread data before a read starts
                if (w_stb_fall) begin
                    w_next    = STROBE;
                    w_latch   = 1'b1;
                    w_set_ovr = 1'b1;
                end else if (w_rd_fall) begin
                    w_next = READING;
                end
            end
            READING: begin
                // Strobe landing on the read's trailing edge is a clean
                // back-to-back transfer, not an overrun; IBF stays set
                if (w_stb_fall) begin
                    w_next    = STROBE;
                    w_latch   = 1'b1;
                    w_set_ovr = ~w_rd_rise;
                end else if (w_rd_rise) begin
                    w_next    = EMPTY;
                    w_clr_ibf = 1'b1;
                end
            end
            default: w_next = EMPTY;
        endcase
    end

    // Handshake state, buffer and registered flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
            InBuf   <= '0;
            IBF     <= 1'b0;
            INTR    <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (!ModeStrobed) begin
            r_state <= EMPTY;
            InBuf   <= PortIn;
            IBF     <= 1'b0;
            INTR    <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch)        InBuf <= PortIn;
            if (w_set_ibf)      IBF   <= 1'b1;
            else if (w_clr_ibf) IBF   <= 1'b0;
            // Starting a read acknowledges any earlier overrun
            if (w_rd_fall)      r_ovr <= 1'b0;
            else if (w_set_ovr) r_ovr <= 1'b1;
            INTR <= (w_next == FULL) && Inte;
        end
    end

    // Port-C status nibble read back through the data-output mux
    always_comb begin
        StatusBits              = '0;
        StatusBits[c_STAT_OVR]  = r_ovr;
        StatusBits[c_STAT_INTR] = INTR;
        StatusBits[c_STAT_IBF]  = IBF;
        StatusBits[c_STAT_INTE] = Inte;
    end

endmodule : strobed_input_port
`default_nettype wire
